// File: rtl/imem_boot_ctrl.sv
// Boot loader: streams a program image into instruction memory while holding the
// cpu in reset, then releases it after a fixed hold and reports completion.
module imem_boot_ctrl #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int RST_HOLD = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              im_en,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;

  state_t            state, state_next;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   addr;
  logic [TO_W-1:0]   idle_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic start_seen, count_ok, start_ok, start_bad;
  logic accept, last_word, timeout, hold_done;

  // Start is only honoured while no load is in flight.
  assign start_seen = start && (state == IDLE || state == RUN);
  assign count_ok   = (word_count != '0) && (word_count <= MAX_WORDS);
  assign start_ok   = start_seen && count_ok;
  assign start_bad  = start_seen && !count_ok;

  assign in_ready  = (state == LOAD);
  assign accept    = in_valid && in_ready;
  assign last_word = accept && (addr == count - ONE);
  assign timeout   = (state == LOAD) && !in_valid && (idle_cnt == TO_W'(TIMEOUT - 1));
  assign hold_done = (hold_cnt == HOLD_W'(RST_HOLD - 1));

  // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_ok) state_next = LOAD;
      LOAD: begin
        if (last_word)    state_next = RELEASE;
        else if (timeout) state_next = IDLE;
      end
      RELEASE: if (hold_done) state_next = RUN;
      RUN:     if (start_ok)  state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      addr      <= '0;
      idle_cnt  <= '0;
      hold_cnt  <= '0;
      im_en     <= 1'b0;
      im_addr   <= '0;
      im_data   <= '0;
      cpu_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      im_en <= accept;
      if (accept) begin
        im_addr <= addr[ADDR_W-1:0];
        im_data <= in_data;
        addr    <= addr + ONE;
      end

      if (start_ok) begin
        count <= word_count;
        addr  <= '0;
        err   <= 1'b0;
      end else if (start_bad || timeout) begin
        err <= 1'b1;
      end

      if (state == LOAD && !in_valid && !timeout) idle_cnt <= idle_cnt + TO_W'(1);
      else                                        idle_cnt <= '0;

      if (state == RELEASE) hold_cnt <= hold_cnt + HOLD_W'(1);
      else                  hold_cnt <= '0;

      // Status outputs follow the state being entered so they line up with it.
      cpu_rst_n <= (state_next == RUN);
      done      <= (state_next == RUN);
      busy      <= (state_next == LOAD) || (state_next == RELEASE);
    end
  end

endmodule
